// File: rtl/tlb_op_ctrl_pkg.sv
// Shared TLB definitions: op codes, sequencer states, array geometry and
// the CP0 EntryHi/EntryLo field positions used by the comparator.
package tlb_op_ctrl_pkg;

  localparam int unsigned TLB_ENTRIES = 32;
  localparam int unsigned TLB_IDXBITS = 5;

  typedef enum logic [1:0] {
    TLBOP_R  = 2'd0,
    TLBOP_WI = 2'd1,
    TLBOP_WR = 2'd2,
    TLBOP_P  = 2'd3
  } tlb_op_e;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRead  = 3'd1,
    StWrite = 3'd2,
    StProbe = 3'd3,
    StDone  = 3'd4
  } tlb_state_e;

  // EntryHi.VPN2 = [31:13], EntryHi.ASID = [7:0], EntryLo.G = [0]
  localparam int unsigned ENTRYHI_VPN2_MSB = 31;
  localparam int unsigned ENTRYHI_VPN2_LSB = 13;
  localparam int unsigned ENTRYHI_ASID_MSB = 7;
  localparam int unsigned ENTRYHI_ASID_LSB = 0;
  localparam int unsigned ENTRYLO_G        = 0;

endpackage

// File: rtl/tlb_match.sv
// Combinational single-entry TLB comparator.
// Ports:
//   va_hi    - EntryHi-format lookup key (VPN2 + ASID)
//   ent_hi   - stored entry EntryHi
//   ent_lo0  - stored entry EntryLo0 (G bit used)
//   ent_lo1  - stored entry EntryLo1 (G bit used)
//   ent_mask - stored PageMask (VA[24:13]); set bits are don't-care in VPN2
//   hit      - entry matches the key
module tlb_match
  import tlb_op_ctrl_pkg::*;
(
  input  logic [31:0] va_hi,
  input  logic [31:0] ent_hi,
  input  logic [31:0] ent_lo0,
  input  logic [31:0] ent_lo1,
  input  logic [11:0] ent_mask,
  output logic        hit
);

  logic [18:0] vpn_diff;
  logic        asid_eq;
  logic        global;
  logic        unused_bits;

  assign vpn_diff = (va_hi[ENTRYHI_VPN2_MSB:ENTRYHI_VPN2_LSB] ^
                     ent_hi[ENTRYHI_VPN2_MSB:ENTRYHI_VPN2_LSB]) & ~{7'b0, ent_mask};
  assign asid_eq  = va_hi[ENTRYHI_ASID_MSB:ENTRYHI_ASID_LSB] ==
                    ent_hi[ENTRYHI_ASID_MSB:ENTRYHI_ASID_LSB];
  // An entry is global only when both halves carry G.
  assign global   = ent_lo0[ENTRYLO_G] & ent_lo1[ENTRYLO_G];
  assign hit      = (vpn_diff == '0) && (global || asid_eq);

  assign unused_bits = ^{va_hi[12:8], ent_hi[12:8], ent_lo0[31:1], ent_lo1[31:1]};

endmodule

// File: rtl/tlb_op_ctrl.sv
// Multi-cycle sequencer for TLBR/TLBWI/TLBWR/TLBP between commit and the
// TLB entry array. One op in flight; TLBP scans entries serially through a
// single tlb_match instance.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   op_valid/op_code/op_ready  - op handshake from commit
//   op_done                    - one-cycle completion pulse
//   cp0_*                      - CP0 operands, sampled only on accept
//   tlb_idx/tlb_we/tlb_w*      - array address, write strobe, write data
//   tlb_r*                     - array read data, one cycle after tlb_idx
//   tlbr/tlbr_*                - CP0 load pulse and data (held between TLBRs)
//   tlbwr                      - CP0 Random advance pulse
//   tlbp/tlbp_index            - CP0 Index update pulse and value (held)
module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
#(
  parameter int unsigned TLB_ENTRIES = tlb_op_ctrl_pkg::TLB_ENTRIES,
  parameter int unsigned IDXBITS     = tlb_op_ctrl_pkg::TLB_IDXBITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  input  logic [1:0]         op_code,
  output logic               op_ready,
  output logic               op_done,
  input  logic [31:0]        cp0_index,
  input  logic [31:0]        cp0_random,
  input  logic [31:0]        cp0_entryhi,
  input  logic [31:0]        cp0_entrylo0,
  input  logic [31:0]        cp0_entrylo1,
  input  logic [11:0]        cp0_mask,
  output logic [IDXBITS-1:0] tlb_idx,
  output logic               tlb_we,
  output logic [31:0]        tlb_whi,
  output logic [31:0]        tlb_wlo0,
  output logic [31:0]        tlb_wlo1,
  output logic [11:0]        tlb_wmask,
  input  logic [31:0]        tlb_rhi,
  input  logic [31:0]        tlb_rlo0,
  input  logic [31:0]        tlb_rlo1,
  input  logic [11:0]        tlb_rmask,
  output logic               tlbr,
  output logic [31:0]        tlbr_hi,
  output logic [31:0]        tlbr_lo0,
  output logic [31:0]        tlbr_lo1,
  output logic [11:0]        tlbr_mask,
  output logic               tlbwr,
  output logic               tlbp,
  output logic [31:0]        tlbp_index
);

  // Probe counter needs one extra count to compare the last entry's data.
  localparam logic [IDXBITS:0] LastCnt = (IDXBITS+1)'(TLB_ENTRIES);

  tlb_state_e         state_q, state_d;
  tlb_op_e            op_q;
  logic [IDXBITS-1:0] idx_q;
  logic [31:0]        hi_q, lo0_q, lo1_q;
  logic [11:0]        mask_q;
  logic [IDXBITS:0]   cnt_q, cnt_d;
  logic [IDXBITS:0]   prev_cnt;
  logic [31:0]        tlbr_hi_q, tlbr_lo0_q, tlbr_lo1_q;
  logic [11:0]        tlbr_mask_q;
  logic [31:0]        tlbp_index_q, probe_result;
  logic               probe_hit;
  logic               accept;
  logic               unused_bits;

  tlb_match u_match (
    .va_hi    (hi_q),
    .ent_hi   (tlb_rhi),
    .ent_lo0  (tlb_rlo0),
    .ent_lo1  (tlb_rlo1),
    .ent_mask (tlb_rmask),
    .hit      (probe_hit)
  );

  assign accept    = (state_q == StIdle) && op_valid;
  assign prev_cnt  = cnt_q - 1'b1;
  assign tlb_whi   = hi_q;
  assign tlb_wlo0  = lo0_q;
  assign tlb_wlo1  = lo1_q;
  assign tlb_wmask = mask_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_ready     = 1'b0;
    op_done      = 1'b0;
    tlb_we       = 1'b0;
    tlb_idx      = '0;
    tlbr         = 1'b0;
    tlbwr        = 1'b0;
    tlbp         = 1'b0;
    probe_result = tlbp_index_q;
    unique case (state_q)
      StIdle: begin
        op_ready = 1'b1;
        cnt_d    = '0;
        if (op_valid) begin
          unique case (tlb_op_e'(op_code))
            TLBOP_R:            state_d = StRead;
            TLBOP_WI, TLBOP_WR: state_d = StWrite;
            TLBOP_P:            state_d = StProbe;
            default:            state_d = StIdle;
          endcase
        end
      end
      StRead: begin
        tlb_idx = idx_q;
        state_d = StDone;
      end
      StDone: begin
        tlbr    = 1'b1;
        op_done = 1'b1;
        state_d = StIdle;
      end
      StWrite: begin
        tlb_idx = idx_q;
        tlb_we  = 1'b1;
        op_done = 1'b1;
        tlbwr   = (op_q == TLBOP_WR);
        state_d = StIdle;
      end
      StProbe: begin
        tlb_idx = cnt_q[IDXBITS-1:0];
        cnt_d   = cnt_q + 1'b1;
        // Read data now on tlb_r* belongs to entry cnt_q-1.
        if (cnt_q != '0 && probe_hit) begin
          tlbp         = 1'b1;
          op_done      = 1'b1;
          probe_result = {{(32-IDXBITS){1'b0}}, prev_cnt[IDXBITS-1:0]};
          state_d      = StIdle;
        end else if (cnt_q == LastCnt) begin
          tlbp         = 1'b1;
          op_done      = 1'b1;
          probe_result = 32'h8000_0000;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // An op interrupted by reset must not write or signal completion.
    if (reset) begin
      tlb_we  = 1'b0;
      op_done = 1'b0;
      tlbr    = 1'b0;
      tlbwr   = 1'b0;
      tlbp    = 1'b0;
    end
  end

  // Results appear in the pulse cycle and are then held by the registers.
  assign tlbr_hi    = tlbr ? tlb_rhi   : tlbr_hi_q;
  assign tlbr_lo0   = tlbr ? tlb_rlo0  : tlbr_lo0_q;
  assign tlbr_lo1   = tlbr ? tlb_rlo1  : tlbr_lo1_q;
  assign tlbr_mask  = tlbr ? tlb_rmask : tlbr_mask_q;
  assign tlbp_index = tlbp ? probe_result : tlbp_index_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      op_q         <= TLBOP_R;
      idx_q        <= '0;
      hi_q         <= '0;
      lo0_q        <= '0;
      lo1_q        <= '0;
      mask_q       <= '0;
      cnt_q        <= '0;
      tlbr_hi_q    <= '0;
      tlbr_lo0_q   <= '0;
      tlbr_lo1_q   <= '0;
      tlbr_mask_q  <= '0;
      tlbp_index_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q   <= tlb_op_e'(op_code);
        idx_q  <= (tlb_op_e'(op_code) == TLBOP_WR) ? cp0_random[IDXBITS-1:0]
                                                   : cp0_index[IDXBITS-1:0];
        hi_q   <= cp0_entryhi;
        lo0_q  <= cp0_entrylo0;
        lo1_q  <= cp0_entrylo1;
        mask_q <= cp0_mask;
      end
      if (tlbr) begin
        tlbr_hi_q   <= tlb_rhi;
        tlbr_lo0_q  <= tlb_rlo0;
        tlbr_lo1_q  <= tlb_rlo1;
        tlbr_mask_q <= tlb_rmask;
      end
      if (tlbp) tlbp_index_q <= probe_result;
    end
  end

  assign unused_bits = ^{cp0_index[31:IDXBITS], cp0_random[31:IDXBITS]};

endmodule
